// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES (Inv)ShiftRows stage: a two-bank ping-pong store takes 16 bytes in stream order
// and plays them back permuted, one byte per cycle on each side.
module inv_shift_rows_stream #(
    parameter int INVERSE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       done
);

    logic [127:0] bank_q [2];
    logic [127:0] bank_d [2];
    logic [1:0]   full_q, full_d;
    logic         wr_sel_q, wr_sel_d;
    logic         rd_sel_q, rd_sel_d;
    logic [3:0]   wr_cnt_q, wr_cnt_d;
    logic [3:0]   rd_cnt_q, rd_cnt_d;
    logic         done_q, done_d;

    logic         wr_fire, rd_fire;
    logic [1:0]   src_col;
    logic [3:0]   src_idx;

    // Output byte at (row r, col c) comes from (r, c -/+ r); 2-bit arithmetic gives the mod 4.
    always_comb begin
        if (INVERSE != 0) begin
            src_col = rd_cnt_q[3:2] - rd_cnt_q[1:0];
        end else begin
            src_col = rd_cnt_q[3:2] + rd_cnt_q[1:0];
        end
        src_idx = {src_col, rd_cnt_q[1:0]};
    end

    always_comb begin
        in_ready  = !full_q[wr_sel_q];
        out_valid = full_q[rd_sel_q];
        wr_fire   = in_valid && in_ready;
        rd_fire   = out_valid && out_ready;
        out_data  = out_valid ? bank_q[rd_sel_q][{src_idx, 3'b000} +: 8] : '0;
        out_last  = out_valid && (rd_cnt_q == 4'd15);
        done      = done_q;
    end

    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        full_d    = full_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        done_d    = 1'b0;

        if (wr_fire) begin
            bank_d[wr_sel_q][{wr_cnt_q, 3'b000} +: 8] = in_data;
            wr_cnt_d = wr_cnt_q + 4'd1;
            if (wr_cnt_q == 4'd15) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = !wr_sel_q;
            end
        end

        // Write and read always address different banks, so both flag updates can land together.
        if (rd_fire) begin
            rd_cnt_d = rd_cnt_q + 4'd1;
            if (rd_cnt_q == 4'd15) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = !rd_sel_q;
                done_d           = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            full_q    <= '0;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            full_q    <= full_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Scoreboarded bench: inverse instance checked byte by byte; a forward instance feeding an inverse one
// checks forward ordering and identity loopback.
module tb_inv_shift_rows_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       done;

    logic       f_en;
    logic       f_in_valid, f_in_ready, f_out_valid, f_out_last, f_done;
    logic [7:0] f_out_data;
    logic       lb_in_ready, lb_out_valid, lb_out_ready, lb_out_last, lb_done;
    logic [7:0] lb_out_data;

    always #5 clk = !clk;
    assign f_in_valid = in_valid && f_en;

    inv_shift_rows_stream #(.INVERSE(1)) u_dut (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done(done)
    );

    inv_shift_rows_stream #(.INVERSE(0)) u_fwd (
        .clk(clk), .reset(rst_n),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(in_data),
        .out_valid(f_out_valid), .out_ready(lb_in_ready), .out_data(f_out_data),
        .out_last(f_out_last), .done(f_done)
    );

    inv_shift_rows_stream #(.INVERSE(1)) u_lb (
        .clk(clk), .reset(rst_n),
        .in_valid(f_out_valid), .in_ready(lb_in_ready), .in_data(f_out_data),
        .out_valid(lb_out_valid), .out_ready(lb_out_ready), .out_data(lb_out_data),
        .out_last(lb_out_last), .done(lb_done)
    );

    int unsigned INV_TAB [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
    int unsigned FWD_TAB [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard state
    logic [7:0] exp_q [$];
    logic [7:0] fq [$];
    logic [7:0] lq [$];
    logic [7:0] ibuf [16];
    logic [7:0] fbuf [16];
    int         icnt, fcnt;
    logic [3:0] opos, fpos, lpos;
    logic       mon_en, exp_done, nxt_done, stalled, held_last;
    logic [7:0] held_data;
    logic       gap_chk, have_prev;
    int         cyc, prev_cyc;
    int         f_done_cnt, lb_done_cnt;
    logic       rnd_ready, rnd_gap;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (in_valid && in_ready) begin
                ibuf[icnt] = in_data;
                icnt++;
                if (icnt == 16) begin
                    for (int k = 0; k < 16; k++) exp_q.push_back(ibuf[INV_TAB[k]]);
                    icnt = 0;
                end
            end
            chk("done", done, exp_done);
            nxt_done = 1'b0;
            if (stalled) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held_data);
                chk("hold_last", out_last, held_last);
            end
            if (out_valid) begin
                chk("last", out_last, opos == 4'd15);
                if (out_ready) begin
                    chk("sb_has_entry", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("data", out_data, exp_q.pop_front());
                    nxt_done = (opos == 4'd15);
                    opos++;
                    if (gap_chk) begin
                        if (have_prev) chk("gapless", cyc, prev_cyc + 1);
                        prev_cyc  = cyc;
                        have_prev = 1'b1;
                    end
                end
            end else begin
                chk("idle_data", out_data, 0);
                chk("idle_last", out_last, 0);
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            exp_done  = nxt_done;

            if (f_in_valid && f_in_ready) begin
                fbuf[fcnt] = in_data;
                fcnt++;
                if (fcnt == 16) begin
                    for (int k = 0; k < 16; k++) begin
                        fq.push_back(fbuf[FWD_TAB[k]]);
                        lq.push_back(fbuf[k]);
                    end
                    fcnt = 0;
                end
            end
            if (f_out_valid && lb_in_ready) begin
                chk("fwd_has_entry", fq.size() != 0, 1);
                if (fq.size() != 0) chk("fwd_data", f_out_data, fq.pop_front());
                chk("fwd_last", f_out_last, fpos == 4'd15);
                fpos++;
            end
            if (lb_out_valid && lb_out_ready) begin
                chk("loop_has_entry", lq.size() != 0, 1);
                if (lq.size() != 0) chk("loop_data", lb_out_data, lq.pop_front());
                chk("loop_last", lb_out_last, lpos == 4'd15);
                lpos++;
            end
            if (f_done) f_done_cnt++;
            if (lb_done) lb_done_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic need_ready);
        logic acc;
        acc = 1'b0;
        if (rnd_gap && ($urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 500; t++) begin
            acc = in_ready;
            if (need_ready) chk("in_ready_streaming", acc, 1);
            if (f_en) chk("fwd_in_ready", f_in_ready, 1);
            tick();
            if (acc) break;
        end
        chk("in_accept_timeout", acc, 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 5000; t++) begin
            if (exp_q.size() == 0 && fq.size() == 0 && lq.size() == 0) break;
            tick();
        end
        chk("drain_main", exp_q.size(), 0);
        chk("drain_fwd", fq.size(), 0);
        chk("drain_loop", lq.size(), 0);
        repeat (2) tick();
    endtask

    task automatic do_reset();
        mon_en   = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        exp_q.delete(); fq.delete(); lq.delete();
        icnt = 0; fcnt = 0; opos = '0; fpos = '0; lpos = '0;
        exp_done = 1'b0; stalled = 1'b0; have_prev = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        int acc_cnt;
        cyc = 0; prev_cyc = 0; gap_chk = 1'b0;
        f_done_cnt = 0; lb_done_cnt = 0;
        rnd_ready = 1'b0; rnd_gap = 1'b0;
        f_en = 1'b0; lb_out_ready = 1'b1;
        in_data = '0; out_ready = 1'b0;
        do_reset();

        // basic inverse plus forward/loopback, 00..0F
        out_ready = 1'b1;
        f_en = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
        in_valid = 1'b0;
        drain();
        f_en = 1'b0;
        chk("fwd_done_pulses", f_done_cnt, 1);
        chk("loop_done_pulses", lb_done_cnt, 1);

        // ping-pong full: 40 offers with out_ready low
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            logic acc;
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + acc_cnt);
            acc = in_ready;
            tick();
            if (acc) acc_cnt++;
        end
        in_valid = 1'b0;
        chk("pp_accepted", acc_cnt, 32);
        chk("pp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) chk("pp_in_ready_before_drain", in_ready, 0);
            if (i == 16) chk("pp_in_ready_after_drain", in_ready, 1);
        end
        drain();

        // back-to-back blocks with no gaps
        gap_chk = 1'b1;
        have_prev = 1'b0;
        for (int i = 0; i < 48; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        in_valid = 1'b0;
        drain();
        gap_chk = 1'b0;

        // random valid/ready over 100 blocks
        rnd_ready = 1'b1;
        rnd_gap = 1'b1;
        for (int i = 0; i < 1600; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        in_valid = 1'b0;
        rnd_ready = 1'b0;
        rnd_gap = 1'b0;
        out_ready = 1'b1;
        drain();

        // reset after 7 input bytes
        for (int i = 0; i < 7; i++) send_byte(8'(8'h80 + i), 1'b1);
        do_reset();

        // reset after 5 output bytes
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i), 1'b1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("pre_reset_out_valid", out_valid, 1);
        do_reset();

        // fresh block 10..1F after reset
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b1);
        in_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
